// File: rtl/tlul_host_arb_if.sv
// tlul_host_arb_if: A-channel request/grant and D-channel response bundle for tlul_host_arb.
interface tlul_host_arb_if #(
    parameter int N    = 4,
    parameter int IdxW = $clog2(N)
);
    logic [N-1:0]    req_i;
    logic [N-1:0]    gnt_o;
    logic [IdxW-1:0] idx_o;
    logic            valid_o;
    logic            ready_i;
    logic            rsp_valid_i;
    logic            rsp_ready_i;
    logic [IdxW-1:0] rsp_idx_i;
    logic            busy_o;
    logic            err_o;
    modport slave (
        input  req_i, ready_i, rsp_valid_i, rsp_ready_i, rsp_idx_i,
        output gnt_o, idx_o, valid_o, busy_o, err_o
    );
    modport master (
        output req_i, ready_i, rsp_valid_i, rsp_ready_i, rsp_idx_i,
        input  gnt_o, idx_o, valid_o, busy_o, err_o
    );
endinterface

// File: rtl/tlul_host_arb.sv
// tlul_host_arb: round-robin TL-UL host arbiter with grant lock and per-host outstanding limits.
// Define TLUL_ARB_WEIGHT_EN to add per-host Weight bursts before the pointer advances.
module tlul_host_arb #(
    parameter int N      = 4,
    parameter int MaxOut = 2,
    parameter int IdxW   = $clog2(N)
`ifdef TLUL_ARB_WEIGHT_EN
    ,
    parameter logic [N*4-1:0] Weight = {N{4'h1}}
`endif
) (
    input logic            clk_i,
    input logic            rst_i,
    tlul_host_arb_if.slave bus
);
    localparam int CW = $clog2(MaxOut + 1);
    typedef enum logic {ARB, LOCK} state_t;
    state_t          state, state_nx;
    logic [IdxW-1:0] ptr, ptr_nx, lock_idx, lock_nx, win, sel, sel_inc, j;
    logic [CW-1:0]   cnt [N];
    logic [CW-1:0]   cnt_nx [N];
    logic [N-1:0]    elig;
    logic            found, valid, accept, rsp, inc, hit, busy, busy_nx, err, err_nx;

    for (genvar i = 0; i < N; i++) begin : g_elig
        assign elig[i] = bus.req_i[i] && (int'(cnt[i]) < MaxOut);
    end

    always_comb begin
        win   = '0;
        found = 1'b0;
        j     = '0;
        for (int k = 0; k < N; k++) begin
            j = IdxW'((int'(ptr) + k) % N);
            if (!found && elig[j]) begin
                found = 1'b1;
                win   = j;
            end
        end
    end

    // Reset masks the grant so nothing leaks while state is being forced.
    assign sel         = (state == LOCK) ? lock_idx : win;
    assign valid       = !rst_i && ((state == LOCK) ? bus.req_i[lock_idx] : found);
    assign accept      = valid && bus.ready_i;
    assign sel_inc     = (int'(sel) == N - 1) ? '0 : sel + 1'b1;
    assign bus.valid_o = valid;
    assign bus.idx_o   = valid ? sel : '0;
    assign bus.gnt_o   = valid ? (N'(1) << sel) : '0;
    assign bus.busy_o  = busy;
    assign bus.err_o   = err;

    always_comb begin
        state_nx = state;
        lock_nx  = lock_idx;
        if (state == ARB && valid && !bus.ready_i) begin
            state_nx = LOCK;
            lock_nx  = win;
        end else if (state == LOCK && (accept || !bus.req_i[lock_idx])) begin
            state_nx = ARB;
        end
    end

`ifdef TLUL_ARB_WEIGHT_EN
    logic [3:0]      burst, burst_nx, wt, streak;
    logic [3:0]      wts [N];
    logic [IdxW-1:0] ptr_inc;
    for (genvar i = 0; i < N; i++) begin : g_wt
        assign wts[i] = (Weight[i*4 +: 4] == 4'd0) ? 4'd1 : Weight[i*4 +: 4];
    end
    assign ptr_inc = (int'(ptr) == N - 1) ? '0 : ptr + 1'b1;
    // The pointer parks on the winner until its burst is used up or it stops being eligible.
    always_comb begin
        wt       = wts[sel];
        streak   = (sel == ptr) ? burst + 4'd1 : 4'd1;
        ptr_nx   = ptr;
        burst_nx = burst;
        if (accept) begin
            ptr_nx   = (streak >= wt) ? sel_inc : sel;
            burst_nx = (streak >= wt) ? 4'd0 : streak;
        end else if (burst != 4'd0 && !elig[ptr]) begin
            ptr_nx   = ptr_inc;
            burst_nx = 4'd0;
        end
    end
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) burst <= '0;
        else burst <= burst_nx;
    end
`else
    assign ptr_nx = accept ? sel_inc : ptr;
`endif

    // An accept and a response on the same host cancel; a response at zero holds and flags.
    always_comb begin
        rsp     = bus.rsp_valid_i && bus.rsp_ready_i;
        err_nx  = rsp && (int'(bus.rsp_idx_i) >= N);
        busy_nx = 1'b0;
        inc     = 1'b0;
        hit     = 1'b0;
        for (int i = 0; i < N; i++) begin
            inc       = accept && (sel == IdxW'(i));
            hit       = rsp && (bus.rsp_idx_i == IdxW'(i));
            cnt_nx[i] = cnt[i];
            if (hit && cnt[i] == '0) err_nx = 1'b1;
            if (inc && !hit) cnt_nx[i] = cnt[i] + 1'b1;
            else if (hit && !inc && cnt[i] != '0) cnt_nx[i] = cnt[i] - 1'b1;
            busy_nx = busy_nx || (cnt_nx[i] != '0);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state    <= ARB;
            ptr      <= '0;
            lock_idx <= '0;
            busy     <= 1'b0;
            err      <= 1'b0;
            for (int i = 0; i < N; i++) cnt[i] <= '0;
        end else begin
            state    <= state_nx;
            ptr      <= ptr_nx;
            lock_idx <= lock_nx;
            busy     <= busy_nx;
            err      <= err_nx;
            cnt      <= cnt_nx;
        end
    end
endmodule

// File: tb/tb_tlul_host_arb.sv
// tb_tlul_host_arb: directed and randomized checks of tlul_host_arb (N=4, MaxOut=2)
// against a behavioural model of grants, lock hold and outstanding counts.
module tb_tlul_host_arb;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests = 0;
    int   fails = 0;
    int   mcnt [4];
    int   mptr, mlock;
    bit   merr, mbusy;

    tlul_host_arb_if #(.N(4)) b ();
    tlul_host_arb #(.N(4), .MaxOut(2)) dut (.clk_i(clk), .rst_i(rst), .bus(b));

    always #5 clk = ~clk;

    function automatic int exp_win();
        if (mlock >= 0) return b.req_i[2'(mlock)] ? mlock : -1;
        for (int k = 0; k < 4; k++) begin
            int h;
            h = (mptr + k) % 4;
            if (b.req_i[2'(h)] && mcnt[h] < 2) return h;
        end
        return -1;
    endfunction

    function automatic logic [3:0] egnt(int w);
        return (w < 0) ? 4'b0000 : 4'(1 << w);
    endfunction

    function automatic logic [1:0] eidx(int w);
        return (w < 0) ? 2'd0 : 2'(w);
    endfunction

    // Advance the model over one clock edge using the inputs currently driven.
    task automatic tick();
        int w, r;
        bit acc, rs;
        w   = exp_win();
        acc = (w >= 0) && b.ready_i;
        rs  = b.rsp_valid_i && b.rsp_ready_i;
        r   = int'(b.rsp_idx_i);
        merr = rs && mcnt[r] == 0;
        if (rs && !(acc && r == w) && mcnt[r] > 0) mcnt[r]--;
        if (acc && !(rs && r == w)) mcnt[w]++;
        if (acc) begin
            mptr  = (w + 1) % 4;
            mlock = -1;
        end else begin
            mlock = w;
        end
        mbusy = (mcnt[0] + mcnt[1] + mcnt[2] + mcnt[3]) != 0;
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear();
        mptr = 0; mlock = -1; merr = 0; mbusy = 0;
        for (int i = 0; i < 4; i++) mcnt[i] = 0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        b.req_i = '0; b.ready_i = 1'b0; b.rsp_valid_i = 1'b0; b.rsp_ready_i = 1'b0; b.rsp_idx_i = '0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_clear();
    endtask

    task automatic test_reset();
        b.req_i = 4'b1111; b.ready_i = 1'b1; b.rsp_valid_i = 1'b0; b.rsp_ready_i = 1'b0; b.rsp_idx_i = '0;
        #2;
        tests++; if (b.gnt_o !== 4'b0000) begin fails++; $display("FAIL reset_gnt: got %b want 0000", b.gnt_o); end
        tests++; if (b.valid_o !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b want 0", b.valid_o); end
        tests++; if (b.idx_o !== 2'd0) begin fails++; $display("FAIL reset_idx: got %0d want 0", b.idx_o); end
        tests++; if (b.busy_o !== 1'b0 || b.err_o !== 1'b0) begin fails++; $display("FAIL reset_busy_err: got %b/%b want 0/0", b.busy_o, b.err_o); end
        @(posedge clk);
        #1;
        tests++; if (b.gnt_o !== 4'b0000) begin fails++; $display("FAIL reset_gnt_held: got %b want 0000", b.gnt_o); end
        rst = 1'b0;
        model_clear();
        #4;
        tests++; if (b.gnt_o !== 4'b0001) begin fails++; $display("FAIL reset_first_gnt: got %b want 0001", b.gnt_o); end
        tick();
    endtask

    task automatic test_round_robin();
        logic [3:0] seq [8] = '{4'd1, 4'd2, 4'd4, 4'd8, 4'd1, 4'd2, 4'd4, 4'd8};
        do_reset();
        b.req_i = 4'b1111; b.ready_i = 1'b1;
        for (int k = 0; k < 8; k++) begin
            #4;
            tests++; if (b.gnt_o !== seq[k]) begin fails++; $display("FAIL rr_gnt[%0d]: got %b want %b", k, b.gnt_o, seq[k]); end
            tick();
        end
        #4;
        tests++; if (b.valid_o !== 1'b0 || b.gnt_o !== 4'b0000) begin fails++; $display("FAIL rr_saturated: valid/gnt %b/%b want 0/0000", b.valid_o, b.gnt_o); end
        for (int h = 0; h < 4; h++) begin
            tests++; if (int'(dut.cnt[2'(h)]) !== 2) begin fails++; $display("FAIL rr_cnt[%0d]: got %0d want 2", h, dut.cnt[2'(h)]); end
        end
        tests++; if (b.busy_o !== 1'b1) begin fails++; $display("FAIL rr_busy: got %b want 1", b.busy_o); end
        tick();
    endtask

    task automatic test_lock_hold();
        do_reset();
        for (int k = 0; k < 4; k++) begin
            b.req_i = 4'b0101; b.ready_i = (k == 3);
            #4;
            tests++; if (b.gnt_o !== 4'b0001) begin fails++; $display("FAIL lock_hold[%0d]: got %b want 0001", k, b.gnt_o); end
            tick();
        end
        b.ready_i = 1'b1;
        #4;
        tests++; if (b.gnt_o !== 4'b0100) begin fails++; $display("FAIL lock_next: got %b want 0100", b.gnt_o); end
        tick();
    endtask

    task automatic test_lock_drop();
        do_reset();
        b.req_i = 4'b0100; b.ready_i = 1'b0;
        #4;
        tests++; if (b.gnt_o !== 4'b0100) begin fails++; $display("FAIL drop_lock: got %b want 0100", b.gnt_o); end
        tick();
        b.req_i = 4'b1000;
        #4;
        tests++; if (b.valid_o !== 1'b0 || b.gnt_o !== 4'b0000) begin fails++; $display("FAIL drop_cycle: valid/gnt %b/%b want 0/0000", b.valid_o, b.gnt_o); end
        tick();
        #4;
        tests++; if (b.gnt_o !== 4'b1000) begin fails++; $display("FAIL drop_next: got %b want 1000", b.gnt_o); end
        tick();
    endtask

    task automatic test_same_cycle();
        do_reset();
        b.req_i = 4'b0010; b.ready_i = 1'b1;
        #4;
        tick();
        b.rsp_valid_i = 1'b1; b.rsp_ready_i = 1'b1; b.rsp_idx_i = 2'd1;
        #4;
        tests++; if (b.gnt_o !== 4'b0010) begin fails++; $display("FAIL same_gnt: got %b want 0010", b.gnt_o); end
        tick();
        tests++; if (int'(dut.cnt[1]) !== 1) begin fails++; $display("FAIL same_cnt: got %0d want 1", dut.cnt[1]); end
        tests++; if (b.err_o !== 1'b0) begin fails++; $display("FAIL same_err: got %b want 0", b.err_o); end
        b.rsp_valid_i = 1'b0; b.req_i = '0;
        tick();
    endtask

    task automatic test_err();
        do_reset();
        b.rsp_valid_i = 1'b1; b.rsp_ready_i = 1'b1; b.rsp_idx_i = 2'd3;
        #4;
        tick();
        tests++; if (b.err_o !== 1'b1) begin fails++; $display("FAIL err_pulse: got %b want 1", b.err_o); end
        tests++; if (int'(dut.cnt[3]) !== 0) begin fails++; $display("FAIL err_cnt: got %0d want 0", dut.cnt[3]); end
        b.rsp_valid_i = 1'b0;
        #4;
        tick();
        tests++; if (b.err_o !== 1'b0) begin fails++; $display("FAIL err_width: got %b want 0", b.err_o); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        b.req_i = 4'b0010; b.ready_i = 1'b1;
        #4; tick();
        #4; tick();
        b.req_i = 4'b0100; b.ready_i = 1'b0;
        #4; tick();
        tests++; if (b.busy_o !== 1'b1 || b.valid_o !== 1'b1) begin fails++; $display("FAIL mid_pre: busy/valid %b/%b want 1/1", b.busy_o, b.valid_o); end
        #2;
        rst = 1'b1;
        #1;
        tests++; if (b.gnt_o !== 4'b0000 || b.valid_o !== 1'b0) begin fails++; $display("FAIL mid_async: gnt/valid %b/%b want 0000/0", b.gnt_o, b.valid_o); end
        tests++; if (b.busy_o !== 1'b0) begin fails++; $display("FAIL mid_busy: got %b want 0", b.busy_o); end
        b.req_i = 4'b1111; b.ready_i = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_clear();
        #4;
        tests++; if (b.gnt_o !== 4'b0001) begin fails++; $display("FAIL mid_release: got %b want 0001", b.gnt_o); end
        tick();
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 400; c++) begin
            int w;
            b.req_i       = 4'($urandom);
            b.ready_i     = $urandom_range(0, 3) != 0;
            b.rsp_valid_i = 1'($urandom_range(0, 1));
            b.rsp_ready_i = $urandom_range(0, 3) != 0;
            b.rsp_idx_i   = 2'($urandom);
            #4;
            w = exp_win();
            tests++;
            if (b.valid_o !== (w >= 0) || b.gnt_o !== egnt(w) || b.idx_o !== eidx(w)) begin
                fails++;
                $display("FAIL rand_grant[%0d]: valid/gnt/idx %b/%b/%0d want %b/%b/%0d", c, b.valid_o, b.gnt_o, b.idx_o, w >= 0, egnt(w), eidx(w));
            end
            tick();
            tests++;
            if (b.busy_o !== mbusy || b.err_o !== merr) begin
                fails++;
                $display("FAIL rand_flags[%0d]: busy/err %b/%b want %b/%b", c, b.busy_o, b.err_o, mbusy, merr);
            end
            for (int h = 0; h < 4; h++) begin
                tests++;
                if (int'(dut.cnt[2'(h)]) !== mcnt[h]) begin
                    fails++;
                    $display("FAIL rand_cnt[%0d][%0d]: got %0d want %0d", c, h, dut.cnt[2'(h)], mcnt[h]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_lock_hold();
        test_lock_drop();
        test_same_cycle();
        test_err();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/tlul_host_arb.md
TLUL_HOST_ARB -- requirements
Module: tlul_host_arb

Interface
REQ-001 SHALL have parameter N, default 4: number of requesting host ports, range 2..16.
REQ-002 SHALL have parameter MaxOut, default 2: maximum outstanding requests per host, range 1..15.
REQ-003 SHALL have parameter IdxW, default $clog2(N): width of host index fields.
REQ-004 SHALL have port clk_i, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-005 SHALL have port rst_i, input, 1 bit: asynchronous, active-high reset.
REQ-006 SHALL have port req_i, input, N bits: per-host A-channel valid.
REQ-007 SHALL have port gnt_o, output, N bits: one-hot grant (A-channel ready to the winning host).
REQ-008 SHALL have port idx_o, output, IdxW bits: index of the granted host; this value is also the host ID carried in the low a_source bits.
REQ-009 SHALL have port valid_o, output, 1 bit: arbitrated request valid toward the device.
REQ-010 SHALL have port ready_i, input, 1 bit: device A-channel ready.
REQ-011 SHALL have ports rsp_valid_i and rsp_ready_i, inputs, 1 bit each: D-channel handshake.
REQ-012 SHALL have port rsp_idx_i, input, IdxW bits: host index decoded from the low d_source bits.
REQ-013 SHALL have port busy_o, output, 1 bit: high when any host has a nonzero outstanding count.
REQ-014 SHALL have port err_o, output, 1 bit: single-cycle pulse on a response for a host with zero outstanding requests, or with rsp_idx_i >= N.

Function
REQ-015 SHALL mark host i eligible when req_i[i]=1 and outstanding count cnt[i] < MaxOut.
REQ-016 SHALL use state machine ARB/LOCK, resetting to ARB.
REQ-017 In ARB, SHALL select the first eligible host at or after round-robin pointer ptr (wrapping N-1 -> 0), assert valid_o, and drive gnt_o and idx_o in the same cycle, giving zero-cycle latency.
REQ-018 In ARB, SHALL hold valid_o=0, gnt_o=0 and idx_o=0 when no host is eligible.
REQ-019 On accept (valid_o & ready_i), SHALL set ptr to winner+1 mod N and stay in ARB.
REQ-020 On ARB with a winner and ready_i=0, SHALL latch the winner and enter LOCK.
REQ-021 In LOCK, SHALL keep the grant on the latched host while its req_i stays high, with no re-arbitration.
REQ-022 In LOCK, SHALL return to ARB on accept, or when the latched host's req_i drops (valid_o=0 that cycle; ptr unchanged).
REQ-023 SHALL increment cnt[i] on accept for host i.
REQ-024 SHALL decrement cnt[rsp_idx_i] on rsp_valid_i & rsp_ready_i.
REQ-025 When an accept and a response hit the same host in one cycle, SHALL leave cnt unchanged.
REQ-026 SHALL not decrement a cnt at 0 (count holds) and SHALL pulse err_o in that case.
REQ-027 SHALL register busy_o as OR over (cnt != 0) after the update, i.e. one cycle after the causing handshake.

Reset
REQ-028 While rst_i is high, SHALL immediately force state=ARB, ptr=0, all cnt=0, latched winner=0, weight counters=0, busy_o=0 and err_o=0.
REQ-029 While rst_i is high, gnt_o=0, valid_o=0 and idx_o=0 SHALL hold regardless of req_i.
REQ-030 SHALL discard any in-flight LOCK or outstanding counts on reset mid-operation; the first cycle after release is a fresh ARB from host 0.

Configuration
REQ-031 With macro TLUL_ARB_WEIGHT_EN defined, SHALL add parameter Weight (N x 4 bits, default all 4'h1) and a per-winner burst counter.
REQ-032 With TLUL_ARB_WEIGHT_EN defined, ptr SHALL advance only after Weight[i] consecutive accepts by host i, or earlier if host i becomes ineligible. A Weight of 0 SHALL be treated as 1.
REQ-033 Without TLUL_ARB_WEIGHT_EN, SHALL omit the Weight parameter and burst counter, giving the plain round robin of REQ-019.

Verification (N=4, MaxOut=2)
REQ-034 Bench SHALL drive req_i=4'b1111 with ready_i=1 for 8 cycles and check gnt_o sequence 1,2,4,8,1,2,4,8 with cnt saturating at 2, after which no grants occur.
REQ-035 Bench SHALL drive req_i=4'b0101 with ready_i=0 for 3 cycles then 1, and check gnt_o=4'b0001 held all 4 cycles, followed by next grant 4'b0100.
REQ-036 Bench SHALL enter LOCK on host 2, then drop req_i[2] with req_i[3]=1, and check valid_o=0 that cycle and gnt_o=4'b1000 the next cycle.
REQ-037 Bench SHALL drive, in one cycle, an accept for host 1 and a response with rsp_idx_i=1 while cnt[1]=1, and check cnt[1]=1 and err_o=0.
REQ-038 Bench SHALL drive a response with rsp_idx_i=3 while cnt[3]=0, and check err_o pulses for 1 cycle and cnt[3]=0.
REQ-039 Bench SHALL assert rst_i asynchronously mid-LOCK with cnt=2, and check gnt_o=0, valid_o=0 and busy_o=0 before the next clock edge, and a grant to host 0 first after release.
